// File: rtl/dmem_latency_responder.sv
// Backing-store responder for dcache line refills and write-backs: one request at a time, fixed latency.
// Optional build macro DMEM_STATS_EN adds saturating read/write completion counters.
module dmem_latency_responder #(
  parameter int LATENCY  = 10,
  parameter int DEPTH    = 512,
  parameter int LINE_LSB = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]  rd_cnt_o,
  output logic [31:0]  wr_cnt_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t             state_reg, state_next;
  logic [7:0]         cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [255:0]       wdata_reg, wdata_next;
  logic               write_reg, write_next;
  logic               ack_next;
  logic               do_access;

  logic [255:0]       mem [DEPTH];

  // Only the line-index field of the address matters; the rest is deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:LINE_LSB+IDX_W], addr_i[LINE_LSB-1:0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    write_next = write_reg;
    ack_next   = 1'b0;
    do_access  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable_i) begin
          idx_next   = addr_i[LINE_LSB +: IDX_W];
          wdata_next = data_i;
          write_next = write_i;
          cnt_next   = 8'(LATENCY - 1);
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 8'd0) begin
          do_access  = 1'b1;
          ack_next   = 1'b1;
          state_next = ST_ACK;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      ack_o     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      wdata_reg <= wdata_next;
      write_reg <= write_next;
      ack_o     <= ack_next;
    end
  end

  // Array port kept in its own process so it maps onto block RAM; reset only gates the write.
  always_ff @(posedge clk_i) begin
    if (do_access && write_reg && !rst_i)
      mem[idx_reg] <= wdata_reg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      data_o <= '0;
    else if (do_access && !write_reg)
      data_o <= mem[idx_reg];
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (do_access) begin
      if (!write_reg && rd_cnt_o != 32'hFFFF_FFFF)
        rd_cnt_o <= rd_cnt_o + 32'd1;
      if (write_reg && wr_cnt_o != 32'hFFFF_FFFF)
        wr_cnt_o <= wr_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_latency_responder.sv
module tb_dmem_latency_responder;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst, enable, write, ack;
  logic [31:0]  addr;
  logic [255:0] wdata, rdata;
  logic         f_rst, f_en, f_write, f_ack;
  logic [31:0]  f_addr;
  logic [255:0] f_wdata, f_rdata;
`ifdef DMEM_STATS_EN
  logic [31:0]  rd_cnt, wr_cnt, f_rd_cnt, f_wr_cnt;
`endif

  always #5 clk = ~clk;

  dmem_latency_responder #(.LATENCY(LAT), .DEPTH(512), .LINE_LSB(5)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(enable),
    .write_i(write), .ack_o(ack), .data_o(rdata)
`ifdef DMEM_STATS_EN
    , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
`endif
  );

  dmem_latency_responder #(.LATENCY(1), .DEPTH(16), .LINE_LSB(5)) dut_fast (
    .clk_i(clk), .rst_i(f_rst), .addr_i(f_addr), .data_i(f_wdata), .enable_i(f_en),
    .write_i(f_write), .ack_o(f_ack), .data_o(f_rdata)
`ifdef DMEM_STATS_EN
    , .rd_cnt_o(f_rd_cnt), .wr_cnt_o(f_wr_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [255:0] mm [int];
  logic [255:0] exp_rd;
  int           exp_rd_cnt, exp_wr_cnt;
  int           written [$];

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % 512);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic req(input logic [31:0] a, input logic [255:0] d, input logic w,
                     input int drop_at, input string tag);
    int lat;
    @(negedge clk);
    enable = 1'b1; addr = a; wdata = d; write = w;
    @(posedge clk); #1;
    lat = 0;
    while (!ack && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (lat == drop_at) begin
        enable = 1'b0; addr = $urandom; wdata = rnd256(); write = ~w;
      end
    end
    chk({tag, "_lat"}, 256'(lat), 256'(LAT));
    if (w) begin
      mm[line_of(a)] = d;
      written.push_back(line_of(a));
      exp_wr_cnt++;
    end else begin
      exp_rd = mm[line_of(a)];
      exp_rd_cnt++;
    end
    chk({tag, "_data"}, rdata, exp_rd);
    enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ackpulse"}, 256'(ack), 256'(1'b0));
    $display("txn %s addr=%08h write=%0b latency=%0d", tag, a, w, lat);
  endtask

  initial begin
    int ack_seen;
    int idx;
    logic [31:0] a;
    logic [255:0] p;

    rst = 1'b1; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    f_rst = 1'b1; f_en = 1'b0; f_write = 1'b0; f_addr = '0; f_wdata = '0;
    exp_rd = '0; exp_rd_cnt = 0; exp_wr_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; f_rst = 1'b0;
    chk("reset_ack", 256'(ack), 256'(1'b0));
    chk("reset_data", rdata, 256'h0);
`ifdef DMEM_STATS_EN
    chk("reset_rdcnt", 256'(rd_cnt), 256'(32'd0));
    chk("reset_wrcnt", 256'(wr_cnt), 256'(32'd0));
`endif

    p = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    req(32'h0, p, 1'b1, 0, "preload0");
    req(32'h0, '0, 1'b0, 0, "read0");

    req(32'h240, {8{32'hDEADBEEF}}, 1'b1, 0, "write240");
    req(32'h240, '0, 1'b0, 0, "read240");

    req(32'h20, rnd256(), 1'b1, 0, "write20");
    req(32'h20, '0, 1'b0, 3, "read20_drop");

    req(32'h400, rnd256(), 1'b1, 0, "pre400");
    @(negedge clk);
    enable = 1'b1; addr = 32'h400; wdata = rnd256(); write = 1'b1;
    @(posedge clk); #1;
    ack_seen = 0;
    repeat (4) begin @(posedge clk); #1; if (ack) ack_seen++; end
    rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    if (ack) ack_seen++;
    repeat (20) begin @(posedge clk); #1; if (ack) ack_seen++; end
    chk("rst_noack", 256'(ack_seen), 256'(0));
    chk("rst_data", rdata, 256'h0);
    exp_rd = '0; exp_rd_cnt = 0; exp_wr_cnt = 0;
    $display("txn rst_abort addr=00000400 write=1 acks=%0d", ack_seen);
    req(32'h400, '0, 1'b0, 0, "read400");

    req(32'h4000, '0, 1'b0, 0, "read4000_wrap");

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        a = $urandom;
        req(a, rnd256(), 1'b1, 0, "rnd_wr");
      end else begin
        idx = written[$urandom_range(written.size() - 1, 0)];
        a = ($urandom & 32'hFFFF_C01F) | (32'(idx) << 5);
        req(a, '0, 1'b0, 0, "rnd_rd");
      end
    end
`ifdef DMEM_STATS_EN
    chk("rdcnt", 256'(rd_cnt), 256'(32'(exp_rd_cnt)));
    chk("wrcnt", 256'(wr_cnt), 256'(32'(exp_wr_cnt)));
`endif

    @(negedge clk);
    f_en = 1'b1; f_addr = 32'h0; f_write = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack_edge%0d", k), 256'(f_ack), 256'((k == 1 || k == 4)));
      if (k == 4) f_en = 1'b0;
    end
`ifdef DMEM_STATS_EN
    chk("b2b_rdcnt", 256'(f_rd_cnt), 256'(32'd2));
    chk("b2b_wrcnt", 256'(f_wr_cnt), 256'(32'd0));
`endif
    $display("txn b2b_fast two reads latency=1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
